ps2_scan_decoder: RTL and testbench

Consumes the byte stream from the PS/2 keyboard receiver (one pulse per received frame) and turns multi-byte scan-code sequences (E0 extended prefix, F0 break prefix, E1 pause sequence) into single key events. Events are buffered in a small FIFO with a valid/ready handshake toward the application logic. The block also maintains a held-key bitmap for the 12 playable keys (Q A W S E D R F T G Y H).

---
 rtl/ps2_pkg.sv | 83 ++++++++
 rtl/ps2_evt_fifo.sv | 54 +++++
 rtl/ps2_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, prefix FSM states and the event record for the PS/2 decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

    // Tracked playable keys (set 2 make codes)
    localparam logic [7:0] SC_Q = 8'h15;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_R = 8'h2D;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_T = 8'h2C;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_Y = 8'h35;
    localparam logic [7:0] SC_H = 8'h33;

    // Prefixes and keyboard housekeeping bytes
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_NUL    = 8'h00;
    localparam logic [7:0] SC_OVR    = 8'hFF;

    // Bytes following E1 that belong to the pause sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int NUM_KEYS  = 12;
    localparam int KEY_Q_IDX = 0;
    localparam int KEY_A_IDX = 1;
    localparam int KEY_W_IDX = 2;
    localparam int KEY_S_IDX = 3;
    localparam int KEY_E_IDX = 4;
    localparam int KEY_D_IDX = 5;
    localparam int KEY_R_IDX = 6;
    localparam int KEY_F_IDX = 7;
    localparam int KEY_T_IDX = 8;
    localparam int KEY_G_IDX = 9;
    localparam int KEY_Y_IDX = 10;
    localparam int KEY_H_IDX = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } ps2_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_evt_t;

    // One-hot position of a tracked key in KEY_HELD; all zeros for untracked codes
    function automatic logic [NUM_KEYS-1:0] key_mask(input logic [7:0] code);
        logic [NUM_KEYS-1:0] m;
        m = '0;
        case (code)
            SC_Q:    m[KEY_Q_IDX] = 1'b1;
            SC_A:    m[KEY_A_IDX] = 1'b1;
            SC_W:    m[KEY_W_IDX] = 1'b1;
            SC_S:    m[KEY_S_IDX] = 1'b1;
            SC_E:    m[KEY_E_IDX] = 1'b1;
            SC_D:    m[KEY_D_IDX] = 1'b1;
            SC_R:    m[KEY_R_IDX] = 1'b1;
            SC_F:    m[KEY_F_IDX] = 1'b1;
            SC_T:    m[KEY_T_IDX] = 1'b1;
            SC_G:    m[KEY_G_IDX] = 1'b1;
            SC_Y:    m[KEY_Y_IDX] = 1'b1;
            SC_H:    m[KEY_H_IDX] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with extra-MSB pointers for full/empty detection.
// Latency: a write is visible at dout the cycle after push; no fall-through.
// Backpressure: push while full is dropped (push_dropped) unless a pop happens in the same cycle.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             push_dropped
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop       = pop && !empty;
    // A pop in the same cycle frees the slot the write needs
    assign do_push      = push && (!full || do_pop);
    assign push_dropped = push && !do_push;
    assign dout         = mem[rd_ptr[AW-1:0]];

    // Pointer and storage update; storage is cleared so the head reads zero after reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Folds PS/2 E0/F0/E1 prefix sequences into single key events and tracks 12 held keys.
// Latency: completing byte in cycle N -> event at FIFO head in N+1 (KEY_HELD also updates end of N).
// Backpressure: EVT_VALID/EVT_READY; a full FIFO drops the event and sets sticky OVERFLOW.
// Option: define PS2_TYPEMATIC_FILTER_EN to suppress repeat makes of already-held tracked keys.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CODE_VALID,
    input  logic [7:0]  CODE,
    input  logic        CODE_ERR,
    output logic        EVT_VALID,
    input  logic        EVT_READY,
    output logic [7:0]  EVT_CODE,
    output logic        EVT_EXT,
    output logic        EVT_BREAK,
    output logic [11:0] KEY_HELD,
    output logic        OVERFLOW
);

    localparam int EVT_W = $bits(ps2_evt_t);

    ps2_state_e          state_q, state_d;
    logic [2:0]          skip_q, skip_d;
    logic                emit;
    ps2_evt_t            evt;
    logic [NUM_KEYS-1:0] key_held_q;
    logic [NUM_KEYS-1:0] evt_mask;
    logic                typematic;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_empty;
    logic                fifo_drop;
    logic                fifo_full_unused;   // drop flag already covers the full case
    logic [EVT_W-1:0]    fifo_dout;
    ps2_evt_t            head;

    // Prefix state and pause skip counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    // Prefix decode: decide next state and whether this byte completes an event
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        emit    = 1'b0;
        evt     = '0;
        if (CODE_VALID) begin
            if (CODE_ERR) begin
                state_d = ST_IDLE;
                skip_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        case (CODE)
                            SC_EXT:   state_d = ST_EXT;
                            SC_BRK:   state_d = ST_BRK;
                            SC_PAUSE: begin
                                state_d = ST_PAUSE;
                                skip_d  = PAUSE_SKIP;
                            end
                            SC_NUL, SC_BAT, SC_ACK, SC_RESEND, SC_OVR: state_d = ST_IDLE;
                            default: begin
                                emit = 1'b1;
                                evt  = '{code: CODE, ext: 1'b0, brk: 1'b0};
                            end
                        endcase
                    end
                    ST_EXT: begin
                        if (CODE == SC_BRK) begin
                            state_d = ST_EXT_BRK;
                        end else if (CODE != SC_EXT) begin
                            emit    = 1'b1;
                            evt     = '{code: CODE, ext: 1'b1, brk: 1'b0};
                            state_d = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        emit    = 1'b1;
                        evt     = '{code: CODE, ext: 1'b0, brk: 1'b1};
                        state_d = ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        emit    = 1'b1;
                        evt     = '{code: CODE, ext: 1'b1, brk: 1'b1};
                        state_d = ST_IDLE;
                    end
                    ST_PAUSE: begin
                        // The last skipped byte completes the sequence
                        if (skip_q <= 3'd1) begin
                            emit    = 1'b1;
                            evt     = '{code: SC_PAUSE, ext: 1'b0, brk: 1'b0};
                            skip_d  = '0;
                            state_d = ST_IDLE;
                        end else begin
                            skip_d = skip_q - 3'd1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        skip_d  = '0;
                    end
                endcase
            end
        end
    end

    assign evt_mask = key_mask(evt.code);

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign typematic = !evt.ext && !evt.brk && (|(evt_mask & key_held_q));
`else
    assign typematic = 1'b0;
`endif

    assign fifo_push = emit && !typematic;
    assign fifo_pop  = EVT_VALID && EVT_READY;

    // Held-key bitmap follows non-extended make/break events, even when the FIFO drops them
    always_ff @(posedge CLK) begin
        if (RST) begin
            key_held_q <= '0;
        end else if (emit && !evt.ext) begin
            key_held_q <= evt.brk ? (key_held_q & ~evt_mask) : (key_held_q | evt_mask);
        end
    end

    // Sticky overflow flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVERFLOW <= 1'b0;
        end else if (fifo_drop) begin
            OVERFLOW <= 1'b1;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .CLK          (CLK),
        .RST          (RST),
        .push         (fifo_push),
        .din          (evt),
        .pop          (fifo_pop),
        .dout         (fifo_dout),
        .full         (fifo_full_unused),
        .empty        (fifo_empty),
        .push_dropped (fifo_drop)
    );

    assign head      = fifo_dout;
    assign EVT_VALID = !fifo_empty;
    assign EVT_CODE  = head.code;
    assign EVT_EXT   = head.ext;
    assign EVT_BREAK = head.brk;
    assign KEY_HELD  = key_held_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor checks each handshake.
// Latency: n/a.
// Backpressure: EVT_READY driven by the stimulus process.
module tb_ps2_scan_decoder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CODE_VALID;
    logic [7:0]  CODE;
    logic        CODE_ERR;
    logic        EVT_VALID;
    logic        EVT_READY;
    logic [7:0]  EVT_CODE;
    logic        EVT_EXT;
    logic        EVT_BREAK;
    logic [11:0] KEY_HELD;
    logic        OVERFLOW;

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp_q[$];

    ps2_scan_decoder #(.FIFO_DEPTH(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CODE_VALID (CODE_VALID),
        .CODE       (CODE),
        .CODE_ERR   (CODE_ERR),
        .EVT_VALID  (EVT_VALID),
        .EVT_READY  (EVT_READY),
        .EVT_CODE   (EVT_CODE),
        .EVT_EXT    (EVT_EXT),
        .EVT_BREAK  (EVT_BREAK),
        .KEY_HELD   (KEY_HELD),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk);
        exp_q.push_back({code, ext, brk});
    endtask

    // One frame pulse followed by one idle cycle; starts and ends just after a rising edge
    task automatic send(input logic [7:0] b, input logic err);
        CODE       = b;
        CODE_ERR   = err;
        CODE_VALID = 1'b1;
        @(posedge CLK); #1;
        CODE_VALID = 1'b0;
        CODE_ERR   = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic do_reset(input int cycles);
        RST = 1'b1;
        repeat (cycles) begin
            @(posedge CLK); #1;
        end
        RST = 1'b0;
    endtask

    // Let the consumer empty the FIFO; a stuck scoreboard counts as a failure
    task automatic drain(input string name);
        EVT_READY = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !EVT_VALID) break;
            @(posedge CLK); #1;
        end
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_valid_low"}, {31'd0, EVT_VALID}, 0);
    endtask

    // Monitor: every accepted head event is compared with the oldest expected one
    always @(negedge CLK) begin
        if (!RST && EVT_VALID && EVT_READY) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_evt: got %h, required none", {EVT_CODE, EVT_EXT, EVT_BREAK});
            end else begin
                check("evt", {22'd0, EVT_CODE, EVT_EXT, EVT_BREAK}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        RST        = 1'b1;
        CODE_VALID = 1'b0;
        CODE       = 8'h00;
        CODE_ERR   = 1'b0;
        EVT_READY  = 1'b1;
        #1;
        do_reset(3);

        // Reset state
        check("rst_valid",    {31'd0, EVT_VALID}, 0);
        check("rst_code",     {24'd0, EVT_CODE}, 0);
        check("rst_ext_brk",  {30'd0, EVT_EXT, EVT_BREAK}, 0);
        check("rst_key_held", {20'd0, KEY_HELD}, 0);
        check("rst_overflow", {31'd0, OVERFLOW}, 0);

        // Plain make and break of A
        expect_evt(8'h1C, 1'b0, 1'b0);
        send(8'h1C, 1'b0);
        check("held_a_set", {20'd0, KEY_HELD}, 32'h002);
        expect_evt(8'h1C, 1'b0, 1'b1);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        check("held_a_clr", {20'd0, KEY_HELD}, 0);

        // Extended make and break never touch KEY_HELD
        expect_evt(8'h75, 1'b1, 1'b0);
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        expect_evt(8'h75, 1'b1, 1'b1);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h75, 1'b0);
        check("held_ext", {20'd0, KEY_HELD}, 0);

        // Pause sequence collapses to one event, then FSM is back in IDLE
        expect_evt(8'hE1, 1'b0, 1'b0);
        send(8'hE1, 1'b0);
        send(8'h14, 1'b0);
        send(8'h77, 1'b0);
        send(8'hE1, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h14, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h77, 1'b0);
        check("held_pause", {20'd0, KEY_HELD}, 0);
        expect_evt(8'h15, 1'b0, 1'b0);
        send(8'h15, 1'b0);
        expect_evt(8'h15, 1'b0, 1'b1);
        send(8'hF0, 1'b0);
        send(8'h15, 1'b0);
        drain("basic");

        // Latency, no bypass, then overflow with EVT_READY low
        EVT_READY = 1'b0;
        expect_evt(8'h15, 1'b0, 1'b0);
        CODE       = 8'h15;
        CODE_VALID = 1'b1;
        check("no_bypass", {31'd0, EVT_VALID}, 0);
        @(posedge CLK); #1;
        CODE_VALID = 1'b0;
        check("latency_valid", {31'd0, EVT_VALID}, 1);
        @(posedge CLK); #1;
        expect_evt(8'h1D, 1'b0, 1'b0);
        send(8'h1D, 1'b0);
        expect_evt(8'h24, 1'b0, 1'b0);
        send(8'h24, 1'b0);
        expect_evt(8'h2D, 1'b0, 1'b0);
        send(8'h2D, 1'b0);
        check("ovf_not_yet", {31'd0, OVERFLOW}, 0);
        send(8'h2C, 1'b0);
        send(8'h35, 1'b0);
        check("ovf_set", {31'd0, OVERFLOW}, 1);
        check("held_after_drop", {20'd0, KEY_HELD}, 32'h555);
        check("head_stable", {24'd0, EVT_CODE}, 32'h15);

        // Write into a full FIFO alongside a pop is accepted
        expect_evt(8'h33, 1'b0, 1'b0);
        CODE       = 8'h33;
        CODE_VALID = 1'b1;
        EVT_READY  = 1'b1;
        @(posedge CLK); #1;
        CODE_VALID = 1'b0;
        EVT_READY  = 1'b0;
        check("head_after_pop", {24'd0, EVT_CODE}, 32'h1D);
        @(posedge CLK); #1;
        check("ovf_sticky", {31'd0, OVERFLOW}, 1);
        check("held_h", {20'd0, KEY_HELD}, 32'hD55);
        drain("overflow");

        // Errored frame aborts the E0 prefix and is itself discarded
        expect_evt(8'h1C, 1'b0, 1'b0);
        send(8'hE0, 1'b0);
        send(8'h1C, 1'b1);
        send(8'h1C, 1'b0);
        check("held_after_err", {20'd0, KEY_HELD}, 32'hD57);
        drain("err");

        // Reset after F0 drops the break prefix, FIFO flags and bitmap
        send(8'hF0, 1'b0);
        do_reset(1);
        check("rst2_overflow", {31'd0, OVERFLOW}, 0);
        check("rst2_key_held", {20'd0, KEY_HELD}, 0);
        check("rst2_valid", {31'd0, EVT_VALID}, 0);
        expect_evt(8'h1C, 1'b0, 1'b0);
        send(8'h1C, 1'b0);
        drain("rst_mid");

        // Typematic repeats of a held tracked key
        do_reset(1);
        expect_evt(8'h15, 1'b0, 1'b0);
`ifndef PS2_TYPEMATIC_FILTER_EN
        expect_evt(8'h15, 1'b0, 1'b0);
        expect_evt(8'h15, 1'b0, 1'b0);
`endif
        expect_evt(8'h15, 1'b0, 1'b1);
        send(8'h15, 1'b0);
        send(8'h15, 1'b0);
        send(8'h15, 1'b0);
        check("held_repeat", {20'd0, KEY_HELD}, 32'h001);
        send(8'hF0, 1'b0);
        send(8'h15, 1'b0);
        check("held_repeat_rel", {20'd0, KEY_HELD}, 0);
        drain("typematic");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
